// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } dmem_state_t;

    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] DMEM_ERR_DATA        = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_watchdog.sv
// Saturating wait-cycle counter; flags the cycle in which a pending request
// has been waiting TIMEOUT_CYCLES cycles (first waiting cycle counts as 1).
module dmem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt;

            // Count completed waiting cycles, clearing between requests.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt <= '0;
                end else if (en && cnt != SAT) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // cnt holds the number of earlier waiting cycles, so this cycle is number cnt+1.
            assign expire = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage data-memory access controller: turns a load/store into a
// req/ack transaction, stalls the pipeline until done, guards with a watchdog.
module data_mem_access
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA       = DMEM_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        addrErrM,
    output logic        busErrM,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    input  logic        dmemAck,
    input  logic [31:0] dmemRData
);

    dmem_state_t state;
    logic        access;
    logic        aligned;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_expire;

    assign access  = memReadM | memWriteM;
    assign aligned = (aluOutM[1:0] == 2'b00);
    assign wd_clr  = (state == ST_IDLE);
    assign wd_en   = (state == ST_BUSY) && !dmemAck;

    dmem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    // Pipeline handshake flags; all forced low while reset is held.
    always_comb begin
        stallM   = 1'b0;
        addrErrM = 1'b0;
        busErrM  = 1'b0;
        if (!rst) begin
            stallM   = ((state == ST_IDLE) && access && aligned) || (state == ST_BUSY);
            addrErrM = (state == ST_IDLE) && access && !aligned;
            busErrM  = wd_expire;
        end
    end

    // Transaction FSM with registered memory-port and load-data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dmemReq   <= 1'b0;
            dmemWe    <= 1'b0;
            dmemAddr  <= '0;
            dmemWData <= '0;
            readDataM <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            dmemReq   <= 1'b1;
                            dmemWe    <= memWriteM;
                            dmemAddr  <= {aluOutM[31:2], 2'b00};
                            dmemWData <= writeDataM;
                            state     <= ST_BUSY;
                        end else begin
                            readDataM <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmemAck) begin
                        readDataM <= dmemWe ? 32'd0 : dmemRData;
                        dmemReq   <= 1'b0;
                        state     <= ST_DONE;
                    end else if (wd_expire) begin
                        readDataM <= dmemWe ? 32'd0 : ERR_DATA;
                        dmemReq   <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Randomized self-checking bench for data_mem_access with a transaction-level model.
module tb_data_mem_access;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM;
    logic [31:0] aluOutM, writeDataM, readDataM;
    logic        stallM, addrErrM, busErrM;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData;
    logic        dmemAck;
    logic [31:0] dmemRData;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    data_mem_access #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memReadM  (memReadM),
        .memWriteM (memWriteM),
        .aluOutM   (aluOutM),
        .writeDataM(writeDataM),
        .readDataM (readDataM),
        .stallM    (stallM),
        .addrErrM  (addrErrM),
        .busErrM   (busErrM),
        .dmemReq   (dmemReq),
        .dmemWe    (dmemWe),
        .dmemAddr  (dmemAddr),
        .dmemWData (dmemWData),
        .dmemAck   (dmemAck),
        .dmemRData (dmemRData)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        memReadM   = 1'b0;
        memWriteM  = 1'b0;
        aluOutM    = $urandom;
        writeDataM = $urandom;
    endtask

    // One instruction in the MEM stage; w = wait cycles before the memory acks.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int unsigned w);
        int unsigned busy_n;
        int unsigned stalls;
        logic        timeout;
        logic        is_wr;
        logic [31:0] exp_rd;

        @(negedge clk);
        memReadM   = rd;
        memWriteM  = wr;
        aluOutM    = addr;
        writeDataM = wdata;
        dmemAck    = 1'($urandom_range(0, 1));
        dmemRData  = $urandom;
        #1;
        check("idle_rd_hold", readDataM, last_rd);
        check("idle_req", {31'd0, dmemReq}, 32'd0);
        check("idle_buserr", {31'd0, busErrM}, 32'd0);

        if (!(rd | wr)) begin
            check("nomem_stall", {31'd0, stallM}, 32'd0);
            check("nomem_addrerr", {31'd0, addrErrM}, 32'd0);
            return;
        end

        if (addr[1:0] != 2'b00) begin
            check("mis_addrerr", {31'd0, addrErrM}, 32'd1);
            check("mis_stall", {31'd0, stallM}, 32'd0);
            last_rd = '0;
            @(negedge clk);
            idle_inputs();
            dmemAck = 1'b0;
            #1;
            check("mis_req", {31'd0, dmemReq}, 32'd0);
            check("mis_rd", readDataM, last_rd);
            check("mis_pulse", {31'd0, addrErrM}, 32'd0);
            return;
        end

        check("acc_stall", {31'd0, stallM}, 32'd1);
        check("acc_addrerr", {31'd0, addrErrM}, 32'd0);
        stalls  = stallM ? 1 : 0;
        timeout = (w + 1 > TO);
        busy_n  = timeout ? TO : w + 1;
        is_wr   = wr;
        exp_rd  = is_wr ? 32'd0 : (timeout ? ERR : rdata);

        for (int unsigned k = 1; k <= busy_n; k++) begin
            @(negedge clk);
            dmemAck   = (k == w + 1);
            dmemRData = (k == w + 1) ? rdata : $urandom;
            #1;
            if (stallM) stalls++;
            check("busy_req", {31'd0, dmemReq}, 32'd1);
            check("busy_we", {31'd0, dmemWe}, {31'd0, is_wr});
            check("busy_addr", dmemAddr, {addr[31:2], 2'b00});
            check("busy_wdata", dmemWData, wdata);
            check("busy_buserr", {31'd0, busErrM}, {31'd0, (timeout && k == TO)});
        end

        @(negedge clk);
        dmemAck   = 1'($urandom_range(0, 1));
        dmemRData = $urandom;
        #1;
        if (stallM) stalls++;
        check("stall_count", stalls, 1 + busy_n);
        check("done_stall", {31'd0, stallM}, 32'd0);
        check("done_rd", readDataM, exp_rd);
        check("done_req", {31'd0, dmemReq}, 32'd0);
        check("done_buserr", {31'd0, busErrM}, 32'd0);
        last_rd = exp_rd;
    endtask

    initial begin
        rst        = 1'b1;
        memReadM   = 1'b1;
        memWriteM  = 1'b0;
        aluOutM    = 32'h0000_0100;
        writeDataM = '0;
        dmemAck    = 1'b0;
        dmemRData  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stallM}, 32'd0);
        check("rst_req", {31'd0, dmemReq}, 32'd0);
        check("rst_rd", readDataM, 32'd0);
        check("rst_addr", dmemAddr, 32'd0);
        check("rst_wdata", dmemWData, 32'd0);
        check("rst_we", {31'd0, dmemWe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Directed cases from the block's intended use
        do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 0);
        do_txn(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'h5555_5555, 3);
        do_txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h7777_7777, 10);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hAAAA_0010, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'hAAAA_0014, 0);
        do_txn(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 1);
        do_txn(1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h0000_5050, TO - 1);
        do_txn(1'b0, 1'b0, 32'h0000_0060, 32'h0, 32'h0, 0);

        // Reset during BUSY followed by a late ack
        @(negedge clk);
        memReadM = 1'b1; memWriteM = 1'b0; aluOutM = 32'h0000_0400; dmemAck = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_req", {31'd0, dmemReq}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy_stall", {31'd0, stallM}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        dmemAck   = 1'b1;
        dmemRData = 32'h9999_9999;
        #1;
        check("rst_abandon_req", {31'd0, dmemReq}, 32'd0);
        check("rst_abandon_rd", readDataM, 32'd0);
        @(negedge clk);
        dmemAck = 1'b0;
        #1;
        check("late_ack_stall", {31'd0, stallM}, 32'd0);
        check("late_ack_req", {31'd0, dmemReq}, 32'd0);
        check("late_ack_rd", readDataM, 32'd0);
        last_rd = '0;

        // Randomized mix of instructions
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if (kind >= 2) a[1:0] = 2'b00;
            else if (kind == 1 && a[1:0] == 2'b00) a[0] = 1'b1;
            do_txn((kind == 0) ? 1'b0 : (kind != 5), (kind == 0) ? 1'b0 : (kind >= 5),
                   a, $urandom, $urandom, $urandom_range(0, TO + 2));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
